// File: rtl/test_run_sequencer.sv
// test_run_sequencer
//   Sweeps the test_idx argument of a generated test module over 0..NUM_IDX-1, running one
//   req/busy/return method call per index. It records the boolean return of each call and
//   flags any call that exceeds a cycle budget.
//
// Ports
//   clk         system clock
//   reset       synchronous active-high reset
//   start       one-cycle pulse; starts a sweep when idle or done, ignored while running
//   dut_req     method request to the test module
//   dut_busy    method busy from the test module
//   dut_return  boolean method return value
//   dut_idx     index argument, stable for the whole call
//   running     high from start acceptance until done
//   done        level, high once the sweep has ended
//   pass        valid with done: every call returned 1 and none timed out
//   fail_count  calls that returned 0 or timed out (saturating)
//   timeout     sticky, some call hit the cycle budget
//   last_idx    index of the most recently completed call
module test_run_sequencer #(
  parameter int unsigned START_DELAY = 100,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int unsigned NUM_IDX     = 4,
  parameter int unsigned IDX_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             dut_req,
  input  logic             dut_busy,
  input  logic             dut_return,
  output logic [IDX_W-1:0] dut_idx,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic [15:0]      fail_count,
  output logic             timeout,
  output logic [IDX_W-1:0] last_idx
);

  localparam int unsigned DW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  // The call counter only needs to reach TIMEOUT-1; the call ends on the next increment.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DW-1:0]    DelayInit = DW'(START_DELAY);
  localparam logic [TW-1:0]    TLast     = TW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(NUM_IDX - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StReq,
    StWait,
    StNext,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             req_q, req_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic        hit_timeout;
  logic [15:0] fail_inc;

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    tcnt_d    = tcnt_q;
    req_d     = req_q;
    idx_d     = idx_q;
    running_d = running_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    last_d    = last_q;

    hit_timeout = (tcnt_q == TLast);
    fail_inc    = (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          dcnt_d    = DelayInit;
          fail_d    = '0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          idx_d     = '0;
          running_d = 1'b1;
          state_d   = StDelay;
        end
      end
      StDelay: begin
        if (dcnt_q == '0) begin
          req_d   = 1'b1;
          tcnt_d  = '0;
          state_d = StReq;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      StReq, StWait: begin
        tcnt_d = tcnt_q + 1'b1;
        // A hung call wins over a busy handshake seen in the same cycle.
        if (hit_timeout) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          fail_d    = fail_inc;
          last_d    = idx_q;
          state_d   = StNext;
        end else if (state_q == StReq) begin
          if (dut_busy) begin
            req_d   = 1'b0;
            state_d = StWait;
          end
        end else if (!dut_busy) begin
          last_d = idx_q;
          if (!dut_return) begin
            fail_d = fail_inc;
          end
          state_d = StNext;
        end
      end
      StNext: begin
        if (idx_q == IdxLast) begin
          done_d    = 1'b1;
          running_d = 1'b0;
          pass_d    = (fail_q == '0) && !timeout_q;
          state_d   = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          req_d   = 1'b1;
          tcnt_d  = '0;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      dcnt_q    <= '0;
      tcnt_q    <= '0;
      req_q     <= 1'b0;
      idx_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      tcnt_q    <= tcnt_d;
      req_q     <= req_d;
      idx_q     <= idx_d;
      running_q <= running_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
    end
  end

  assign dut_req    = req_q;
  assign dut_idx    = idx_q;
  assign running    = running_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_q;
  assign timeout    = timeout_q;
  assign last_idx   = last_q;

endmodule

// File: tb/tb_test_run_sequencer.sv
// Bench for test_run_sequencer. u_dut runs against a behavioural test module (busy for five
// cycles per call, optional zero return or hang on one index); u_dut2 uses a test module that
// never raises busy, so every call times out in REQ.
`timescale 1ns/1ps
module tb_test_run_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start2;
  logic        dut_req, dut_busy, dut_return, running, done, pass, timeout;
  logic [31:0] dut_idx, last_idx;
  logic [15:0] fail_count;
  logic        dut_req2, running2, done2, pass2, timeout2;
  logic [31:0] dut_idx2, last_idx2;
  logic [15:0] fail_count2;
  logic        dut_busy2, dut_return2;

  assign dut_busy2   = 1'b0;
  assign dut_return2 = 1'b1;

  test_run_sequencer #(
    .START_DELAY(100), .TIMEOUT(50), .NUM_IDX(4), .IDX_W(32)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_req(dut_req), .dut_busy(dut_busy),
    .dut_return(dut_return), .dut_idx(dut_idx), .running(running), .done(done), .pass(pass),
    .fail_count(fail_count), .timeout(timeout), .last_idx(last_idx)
  );

  test_run_sequencer #(
    .START_DELAY(0), .TIMEOUT(20), .NUM_IDX(4), .IDX_W(32)
  ) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .dut_req(dut_req2), .dut_busy(dut_busy2),
    .dut_return(dut_return2), .dut_idx(dut_idx2), .running(running2), .done(done2),
    .pass(pass2), .fail_count(fail_count2), .timeout(timeout2), .last_idx(last_idx2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural test module: busy rises the cycle after req is seen and stays high 5 cycles.
  // On hang_idx busy never drops until the sequencer issues its next request.
  int   zero_idx = -1;
  int   hang_idx = -1;
  logic m_active, m_hung;
  int   m_cnt;

  assign dut_return = (int'(dut_idx) != zero_idx);

  always @(posedge clk) begin
    if (reset) begin
      dut_busy <= 1'b0;
      m_active <= 1'b0;
      m_hung   <= 1'b0;
      m_cnt    <= 0;
    end else if (dut_req && (!m_active || m_hung)) begin
      dut_busy <= 1'b1;
      m_active <= 1'b1;
      m_hung   <= (int'(dut_idx) == hang_idx);
      m_cnt    <= 4;
    end else if (m_active && !m_hung) begin
      if (m_cnt == 0) begin
        dut_busy <= 1'b0;
        m_active <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [31:0] idx;
    int          gap;
  } req_t;

  typedef struct {
    logic        pass;
    logic [15:0] fails;
    logic        tmo;
    logic [31:0] last;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_rise = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: each rising dut_req is checked against the expected index and the cycle gap
  // since the previous request (or since start was sampled); each rising done against the
  // expected sweep result.
  initial begin
    logic req_prev, done_prev;
    req_t re;
    res_t rs;
    req_prev  = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dut_req && !req_prev) begin
        if (req_q.size() == 0) begin
          flag("unexpected_req");
        end else begin
          re = req_q.pop_front();
          check("req_idx", dut_idx, re.idx);
          check("req_gap", cyc - last_rise, re.gap);
        end
        last_rise = cyc;
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          rs = res_q.pop_front();
          check("pass", pass, rs.pass);
          check("fail_count", fail_count, rs.fails);
          check("timeout", timeout, rs.tmo);
          check("last_idx", last_idx, rs.last);
          check("running_at_done", running, 0);
        end
      end
      req_prev  = dut_req;
      done_prev = done;
    end
  end

  task automatic push_req(input int idx, input int gap);
    req_t r;
    r.idx = 32'(idx);
    r.gap = gap;
    req_q.push_back(r);
  endtask

  task automatic expect_sweep(input int g0, input int g1, input int g2, input int g3,
                              input logic p, input int f, input logic t);
    res_t r;
    push_req(0, g0);
    push_req(1, g1);
    push_req(2, g2);
    push_req(3, g3);
    r.pass  = p;
    r.fails = 16'(f);
    r.tmo   = t;
    r.last  = 32'd3;
    res_q.push_back(r);
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic pulse_start();
    start     = 1'b1;
    last_rise = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) flag(name);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, dut_req, 0);
    check({tag, "_idx"}, dut_idx, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_last_idx"}, last_idx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n;
    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    check("rst2_req", dut_req2, 0);
    check("rst2_done", done2, 0);
    check("rst2_fail_count", fail_count2, 0);
    reset = 1'b0;
    while (cyc < 9) @(negedge clk);

    // Clean sweep, start sampled at cycle 10: first request at cycle 111.
    expect_sweep(101, 8, 8, 8, 1'b1, 0, 1'b0);
    pulse_start();
    check("running_after_start", running, 1);
    repeat (105) @(negedge clk);
    start = 1'b1;  // mid-sweep, must be ignored
    @(negedge clk);
    start = 1'b0;
    wait_done(300, "done_timeout_clean");

    // Index 2 returns 0.
    zero_idx = 2;
    expect_sweep(101, 8, 8, 8, 1'b0, 1, 1'b0);
    pulse_start();
    wait_done(300, "done_timeout_zero");

    // Restart from DONE: done clears and fail_count restarts at 0.
    zero_idx = -1;
    expect_sweep(101, 8, 8, 8, 1'b1, 0, 1'b0);
    pulse_start();
    check("restart_done_clear", done, 0);
    check("restart_fail_clear", fail_count, 0);
    check("restart_running", running, 1);
    wait_done(300, "done_timeout_restart");

    // Index 1 hangs: timeout after 50 cycles, next request one cycle later, sweep continues.
    hang_idx = 1;
    expect_sweep(101, 8, 51, 8, 1'b0, 1, 1'b1);
    pulse_start();
    wait_done(400, "done_timeout_hang");
    hang_idx = -1;

    // Reset while waiting on index 1.
    push_req(0, 101);
    push_req(1, 8);
    s = cyc + 1;
    pulse_start();
    while (cyc < s + 112) @(negedge clk);
    check("pre_reset_idx", dut_idx, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midrst");
    check("midrst_queue", req_q.size(), 0);
    @(negedge clk);
    expect_sweep(101, 8, 8, 8, 1'b1, 0, 1'b0);
    pulse_start();
    wait_done(300, "done_timeout_after_reset");

    // Never-busy module with START_DELAY=0: 4 calls time out in REQ, done 85 cycles after start.
    start2 = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    check("u2_req_after_start", dut_req2, 0);
    @(negedge clk);
    check("u2_req_next_cycle", dut_req2, 1);
    n = 0;
    while (!done2 && n < 93) begin
      @(negedge clk);
      n++;
    end
    if (!done2) flag("u2_done_timeout");
    check("u2_done_cycle", cyc - s, 85);
    check("u2_fail_count", fail_count2, 4);
    check("u2_timeout", timeout2, 1);
    check("u2_pass", pass2, 0);
    check("u2_last_idx", last_idx2, 3);
    check("u2_running", running2, 0);
    check("u2_req_low", dut_req2, 0);

    repeat (3) @(negedge clk);
    check("req_queue_empty", req_q.size(), 0);
    check("res_queue_empty", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
